// File: rtl/mole_pkg.sv
// Shared constants for the whack-a-mole core: state encoding, level thresholds
// and the LFSR polynomial/seed.
package mole_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GAP  = 2'd1;
  localparam logic [1:0] ST_UP   = 2'd2;

  localparam int unsigned LVL_T0 = 2;
  localparam int unsigned LVL_T1 = 5;
  localparam int unsigned LVL_T2 = 10;

  // Galois right-shift mask for x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_POLY = 8'hB8;
  localparam logic [7:0] LFSR_SEED = 8'h01;

  function automatic logic [1:0] level_of(input logic [31:0] s);
    if (s <= LVL_T0)      return 2'd0;
    else if (s <= LVL_T1) return 2'd1;
    else if (s <= LVL_T2) return 2'd2;
    else                  return 2'd3;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// 8-bit Galois LFSR used to pick the next mole; advances while enable is high.
module mole_lfsr
  import mole_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] value
);

  logic [7:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (enable) value_d = (value_q >> 1) ^ (value_q[0] ? LFSR_POLY : 8'h00);
  end

  always_ff @(posedge clock) begin
    if (reset) value_q <= LFSR_SEED;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/mole_game_core.sv
// Whack-a-mole game core: IDLE/GAP/UP round sequencing, scoring and levels.
// Optional wrong-button penalty is enabled by defining MOLE_GAME_PENALTY_EN.
module mole_game_core
  import mole_pkg::*;
#(
  parameter int unsigned NUM_MOLES  = 3,
  parameter int unsigned SCORE_W    = 8,
  parameter int unsigned CNT_W      = 28,
  parameter int unsigned GAP_CYCLES = 150000000,
  parameter int unsigned UP_BASE    = 100000000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 game,
  input  logic [NUM_MOLES-1:0] button,
  output logic [NUM_MOLES-1:0] mole,
  output logic [SCORE_W-1:0]   score,
  output logic [1:0]           level,
  output logic                 hit_pulse,
  output logic                 miss_pulse
);

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]     up_cnt_q, up_cnt_d;
  logic [NUM_MOLES-1:0] mole_q, mole_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic [NUM_MOLES-1:0] button_q, button_d;
  logic                 game_q, game_d;
  logic                 start_q, start_d;

  logic [7:0]           lfsr_value;
  logic [7:0]           mole_idx;
  logic [NUM_MOLES-1:0] btn_rise;
  logic                 hit_edge;
  logic [CNT_W-1:0]     up_load;

  mole_lfsr u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .enable (game),
    .value  (lfsr_value)
  );

  assign level    = level_of(32'(score_q));
  assign btn_rise = button & ~button_q;
  assign hit_edge = |(btn_rise & mole_q);
  assign mole_idx = lfsr_value % 8'(NUM_MOLES);
  assign up_load  = CNT_W'(UP_BASE) >> level;

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    up_cnt_d  = up_cnt_q;
    mole_d    = mole_q;
    score_d   = score_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    button_d  = button;
    game_d    = game;
    // start is registered so the IDLE->GAP move lands one cycle after the edge
    start_d   = game & ~game_q;

    if (!game) begin
      state_d = ST_IDLE;
      mole_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_q) begin
            state_d   = ST_GAP;
            gap_cnt_d = CNT_W'(GAP_CYCLES);
            score_d   = '0;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q <= CNT_W'(1)) begin
            state_d  = ST_UP;
            mole_d   = NUM_MOLES'(1) << mole_idx;
            up_cnt_d = up_load;
          end else begin
            gap_cnt_d = gap_cnt_q - CNT_W'(1);
          end
        end
        ST_UP: begin
          if (hit_edge) begin
            state_d   = ST_GAP;
            gap_cnt_d = CNT_W'(GAP_CYCLES);
            mole_d    = '0;
            hit_d     = 1'b1;
            if (score_q != '1) score_d = score_q + SCORE_W'(1);
          end else if (up_cnt_q <= CNT_W'(1)) begin
            state_d   = ST_GAP;
            gap_cnt_d = CNT_W'(GAP_CYCLES);
            mole_d    = '0;
            miss_d    = 1'b1;
          end else begin
            up_cnt_d = up_cnt_q - CNT_W'(1);
`ifdef MOLE_GAME_PENALTY_EN
            if (|(btn_rise & ~mole_q) && (score_q != '0)) score_d = score_q - SCORE_W'(1);
`endif
          end
        end
        default: begin
          state_d = ST_IDLE;
          mole_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gap_cnt_q <= '0;
      up_cnt_q  <= '0;
      mole_q    <= '0;
      score_q   <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      button_q  <= '0;
      game_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      up_cnt_q  <= up_cnt_d;
      mole_q    <= mole_d;
      score_q   <= score_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      button_q  <= button_d;
      game_q    <= game_d;
      start_q   <= start_d;
    end
  end

  assign mole       = mole_q;
  assign score      = score_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;

endmodule

// File: tb/tb_mole_game_core.sv
// Scoreboard bench for mole_game_core: stimulus queues expected hit/miss events,
// a negedge monitor pops and checks them as pulses appear.
module tb_mole_game_core;

  localparam int unsigned NM = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          game  = 1'b0;
  logic [NM-1:0] button = '0;
  logic [NM-1:0] mole;
  logic [7:0]    score;
  logic [1:0]    level;
  logic          hit_pulse, miss_pulse;

  int total = 0;
  int bad   = 0;
  int exp_score = 0;

  typedef struct {
    bit is_hit;
    int score;
    int lvl;
    int up_len;
  } exp_t;

  exp_t exp_q[$];

  mole_game_core #(
    .NUM_MOLES  (3),
    .SCORE_W    (8),
    .CNT_W      (28),
    .GAP_CYCLES (4),
    .UP_BASE    (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .game       (game),
    .button     (button),
    .mole       (mole),
    .score      (score),
    .level      (level),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse)
  );

  always #5 clock = ~clock;

  function automatic int lvl_of(input int s);
    if (s <= 2)       return 0;
    else if (s <= 5)  return 1;
    else if (s <= 10) return 2;
    else              return 3;
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
  endfunction

  // Reference LFSR; ref_prev holds the value seen just before the latest edge.
  logic [7:0] ref_lfsr, ref_prev;
  always @(posedge clock) begin
    ref_prev <= ref_lfsr;
    if (reset)     ref_lfsr <= 8'h01;
    else if (game) ref_lfsr <= lfsr_step(ref_lfsr);
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic fail_timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout, required event within cycle budget", name);
  endtask

  // Monitor
  initial begin
    logic [NM-1:0] mole_prev;
    int   up_cnt;
    bit   hit_prev, miss_prev;
    exp_t e;
    mole_prev = '0;
    up_cnt    = 0;
    hit_prev  = 0;
    miss_prev = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        mole_prev = '0;
        hit_prev  = 0;
        miss_prev = 0;
      end else begin
        if (mole != '0 && mole_prev == '0) begin
          up_cnt = 0;
          check("mole_idx", int'(mole), 1 << (ref_prev % 3));
        end
        if (mole != '0) up_cnt++;
        check("pulse_excl", int'(hit_pulse & miss_pulse), 0);
        if (hit_prev)  check("hit_width", int'(hit_pulse), 0);
        if (miss_prev) check("miss_width", int'(miss_pulse), 0);
        if (hit_pulse || miss_pulse) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: got hit=%0d miss=%0d, required none", hit_pulse, miss_pulse);
          end else begin
            e = exp_q.pop_front();
            check("ev_kind_hit", int'(hit_pulse), int'(e.is_hit));
            check("ev_score", int'(score), e.score);
            check("ev_level", int'(level), e.lvl);
            check("ev_mole_clear", int'(mole), 0);
            check("ev_up_len", up_cnt, e.up_len);
          end
        end
        mole_prev = mole;
        hit_prev  = hit_pulse;
        miss_prev = miss_pulse;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_mole(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (mole != '0) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) fail_timeout("wait_mole");
  endtask

  task automatic wait_clear();
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (mole == '0) begin
        ok = 1;
        break;
      end
      tick();
    end
    if (!ok) fail_timeout("wait_clear");
  endtask

  task automatic hit_round(input int press);
    bit   ok;
    exp_t e;
    wait_mole(ok);
    if (!ok) return;
    repeat (press - 1) tick();
    exp_score = (exp_score < 255) ? exp_score + 1 : 255;
    e.is_hit = 1;
    e.score  = exp_score;
    e.lvl    = lvl_of(exp_score);
    e.up_len = press;
    exp_q.push_back(e);
    button = mole;
    tick();
    button = '0;
    tick();
  endtask

  task automatic miss_round(input int up_len);
    bit   ok;
    exp_t e;
    e.is_hit = 0;
    e.score  = exp_score;
    e.lvl    = lvl_of(exp_score);
    e.up_len = up_len;
    exp_q.push_back(e);
    wait_mole(ok);
    if (!ok) return;
    wait_clear();
  endtask

  task automatic wrong_round();
    bit   ok;
    exp_t e;
    wait_mole(ok);
    if (!ok) return;
    e.is_hit = 0;
    e.lvl    = lvl_of(exp_score);
`ifdef MOLE_GAME_PENALTY_EN
    exp_score = (exp_score > 0) ? exp_score - 1 : 0;
`endif
    e.score  = exp_score;
    e.up_len = 16;
    exp_q.push_back(e);
    tick();
    button = {mole[NM-2:0], mole[NM-1]};
    tick();
    button = '0;
    check("wrong_mole_up", int'(mole != '0), 1);
    check("wrong_score", int'(score), exp_score);
    wait_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ok;
    reset  = 1'b1;
    game   = 1'b0;
    button = '0;
    repeat (3) tick();
    check("rst_mole", int'(mole), 0);
    check("rst_score", int'(score), 0);
    check("rst_level", int'(level), 0);
    check("rst_hit", int'(hit_pulse), 0);
    check("rst_miss", int'(miss_pulse), 0);

    reset = 1'b0;
    game  = 1'b1;
    n = 0;
    while (mole == '0 && n < 40) begin
      tick();
      n++;
    end
    check("first_latency", n - 1, 5);
    // five LFSR steps from 8'h01 give 8'hB3 = 179; 179 mod 3 = 2
    check("first_mole", int'(mole), 4);

    hit_round(3);

    // buttons during GAP must be ignored
    button = '1;
    tick();
    button = '0;
    miss_round(16);

    hit_round(1);
    wrong_round();

    while (exp_score < 3) hit_round(1);
    miss_round(8);
    while (exp_score < 11) hit_round(1);
    check("level_at_11", int'(level), 3);
    miss_round(2);

    wait_mole(ok);
    button = mole;
    reset  = 1'b1;
    tick();
    check("rsthit_score", int'(score), 0);
    check("rsthit_mole", int'(mole), 0);
    check("rsthit_pulse", int'(hit_pulse), 0);
    button = '0;
    tick();
    reset = 1'b0;
    exp_score = 0;

    hit_round(1);

    wait_mole(ok);
    tick();
    game = 1'b0;
    tick();
    check("drop_mole", int'(mole), 0);
    check("drop_score", int'(score), 1);
    repeat (12) tick();
    check("idle_mole", int'(mole), 0);
    check("idle_score", int'(score), 1);

    game = 1'b1;
    wait_mole(ok);
    check("restart_score", int'(score), 0);
    tick();
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
